// File: rtl/id_ex_issue_if.sv
// Issue-stage bus bundle: ID instruction, RF read port, EX/MEM/WB bypass sources, ID/EX outputs.
// Latency: none, wires only.
// Backpressure: ex_hold (from downstream) and flush travel in; id_stall travels back to IF/ID.
//
// master: pipeline side driving the ID instruction and bypass sources.
// slave : issue stage (id_ex_issue).
interface id_ex_issue_if #(
    parameter int CTRL_W = 16
);
    // ID instruction
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [4:0]        id_rd;
    logic              id_rd_we;
    logic              id_is_load;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    // register file read port
    logic [4:0]        rf_a1;
    logic [4:0]        rf_a2;
    logic [31:0]       rf_rd1;
    logic [31:0]       rf_rd2;
    // bypass sources
    logic [31:0]       ex_result;
    logic [4:0]        mem_rd;
    logic              mem_rd_we;
    logic [31:0]       mem_data;
    logic [4:0]        wb_rd;
    logic              wb_we;
    logic [31:0]       wb_data;
    // pipeline control
    logic              ex_hold;
    logic              flush;
    logic              id_stall;
    // ID/EX register contents
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_op1;
    logic [31:0]       ex_op2;
    logic [31:0]       ex_imm;
    logic [4:0]        ex_rd;
    logic              ex_rd_we;
    logic              ex_is_load;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       stall_cnt;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_rd_we,
               id_is_load, id_imm, id_ctrl, rf_rd1, rf_rd2, ex_result,
               mem_rd, mem_rd_we, mem_data, wb_rd, wb_we, wb_data, ex_hold, flush,
        input  rf_a1, rf_a2, id_stall, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm,
               ex_rd, ex_rd_we, ex_is_load, ex_ctrl, stall_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_rd_we,
               id_is_load, id_imm, id_ctrl, rf_rd1, rf_rd2, ex_result,
               mem_rd, mem_rd_we, mem_data, wb_rd, wb_we, wb_data, ex_hold, flush,
        output rf_a1, rf_a2, id_stall, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm,
               ex_rd, ex_rd_we, ex_is_load, ex_ctrl, stall_cnt
    );
endinterface

// File: rtl/id_ex_issue.sv
// Decode-to-execute issue: RF read, EX/MEM/WB forwarding, load-use bubble, ID/EX register, stall counter.
// Latency: 1 cycle ID -> ex_*; rf_a1/rf_a2/id_stall are combinational.
// Backpressure: ex_hold freezes ID/EX and raises id_stall; flush overrides both and loads a bubble.
//
// Ports: clk, rst (synchronous, active low); bus (id_ex_issue_if.slave) carries the ID
// instruction, RF read port, bypass sources, hold/flush, ID/EX outputs and stall_cnt.
module id_ex_issue #(
    parameter int CTRL_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_issue_if.slave  bus
);

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       op1;
        logic [31:0]       op2;
        logic [31:0]       imm;
        logic [4:0]        rd;
        logic              rd_we;
        logic              is_load;
        logic [CTRL_W-1:0] ctrl;
    } idex_t;

    idex_t       idex_q;
    idex_t       idex_d;
    logic [31:0] stall_cnt_q;

    logic        ex_we_eff;
    logic        ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic        load_use;
    logic [31:0] op1_fwd, op2_fwd;

    function automatic logic src_match(input logic rd_en, input logic [4:0] rs,
                                       input logic we, input logic [4:0] rd);
        return rd_en && (rs != 5'd0) && we && (rd == rs);
    endfunction

    // Priority EX (non-load) > MEM > WB > RF. An EX load match falls through to the
    // later stages; that case is always bubbled by load_use, so the value is unused.
    function automatic logic [31:0] fwd_sel(input logic [4:0] rs, input logic ex_m,
                                            input logic ex_ld, input logic [31:0] ex_v,
                                            input logic mem_m, input logic [31:0] mem_v,
                                            input logic wb_m, input logic [31:0] wb_v,
                                            input logic [31:0] rf_v);
        if (rs == 5'd0)          return 32'd0;
        else if (ex_m && !ex_ld) return ex_v;
        else if (mem_m)          return mem_v;
        else if (wb_m)           return wb_v;
        else                     return rf_v;
    endfunction

    assign bus.rf_a1 = bus.id_rs1;
    assign bus.rf_a2 = bus.id_rs2;

    assign ex_we_eff = idex_q.valid & idex_q.rd_we;

    assign ex_m1  = src_match(bus.id_use1, bus.id_rs1, ex_we_eff,     idex_q.rd);
    assign ex_m2  = src_match(bus.id_use2, bus.id_rs2, ex_we_eff,     idex_q.rd);
    assign mem_m1 = src_match(bus.id_use1, bus.id_rs1, bus.mem_rd_we, bus.mem_rd);
    assign mem_m2 = src_match(bus.id_use2, bus.id_rs2, bus.mem_rd_we, bus.mem_rd);
    assign wb_m1  = src_match(bus.id_use1, bus.id_rs1, bus.wb_we,     bus.wb_rd);
    assign wb_m2  = src_match(bus.id_use2, bus.id_rs2, bus.wb_we,     bus.wb_rd);

    assign op1_fwd = fwd_sel(bus.id_rs1, ex_m1, idex_q.is_load, bus.ex_result,
                             mem_m1, bus.mem_data, wb_m1, bus.wb_data, bus.rf_rd1);
    assign op2_fwd = fwd_sel(bus.id_rs2, ex_m2, idex_q.is_load, bus.ex_result,
                             mem_m2, bus.mem_data, wb_m2, bus.wb_data, bus.rf_rd2);

    // Stall logic depends only on registered ID/EX state and ID fields, never on ex_result.
    assign load_use     = bus.id_valid & (ex_m1 | ex_m2) & idex_q.is_load;
    assign bus.id_stall = (load_use | bus.ex_hold) & ~bus.flush;

    always_comb begin
        idex_d = '0;
        if (bus.flush) begin
            idex_d = '0;
        end else if (bus.ex_hold) begin
            idex_d = idex_q;
        end else if (load_use) begin
            idex_d = '0;
        end else begin
            idex_d.valid   = bus.id_valid;
            idex_d.pc      = bus.id_pc;
            idex_d.op1     = op1_fwd;
            idex_d.op2     = op2_fwd;
            idex_d.imm     = bus.id_imm;
            idex_d.rd      = bus.id_rd;
            idex_d.rd_we   = bus.id_rd_we & bus.id_valid;
            idex_d.is_load = bus.id_is_load & bus.id_valid;
            idex_d.ctrl    = bus.id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_q      <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            idex_q <= idex_d;
            if (bus.id_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.ex_valid   = idex_q.valid;
    assign bus.ex_pc      = idex_q.pc;
    assign bus.ex_op1     = idex_q.op1;
    assign bus.ex_op2     = idex_q.op2;
    assign bus.ex_imm     = idex_q.imm;
    assign bus.ex_rd      = idex_q.rd;
    assign bus.ex_rd_we   = idex_q.rd_we;
    assign bus.ex_is_load = idex_q.is_load;
    assign bus.ex_ctrl    = idex_q.ctrl;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

Decode-to-execute issue stage of the pipelined CPU. It drives the register file read addresses, takes the combinational read data, and resolves RAW hazards by forwarding from EX, MEM and WB. It detects load-use hazards and inserts bubbles, and it owns the ID/EX pipeline register that feeds the ALU stage. It also counts stall cycles for performance monitoring.

## Interface
- CTRL_W, 16, width of the opaque decoded control bundle carried to EX
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_pc  in  32  PC of the ID instruction
- id_rs1, id_rs2  in  5  source register numbers
- id_use1, id_use2  in  1  instruction actually reads rs1 / rs2
- id_rd  in  5  destination register
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_imm  in  32  sign-extended immediate
- id_ctrl  in  CTRL_W  decoded control bundle
- rf_a1, rf_a2  out  5  register file read addresses (= id_rs1, id_rs2, combinational)
- rf_rd1, rf_rd2  in  32  register file read data
- ex_result  in  32  EX-stage ALU result for the instruction currently in ID/EX
- mem_rd  in  5, mem_rd_we  in  1, mem_data  in  32  MEM-stage destination, write enable, result (load data for loads)
- wb_rd  in  5, wb_we  in  1, wb_data  in  32  WB-stage write port, also driving the RF
- ex_hold  in  1  downstream not ready; freeze ID/EX
- flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
- id_stall  out  1  hold IF/ID and PC this cycle (combinational)
- ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_rd_we, ex_is_load, ex_ctrl  out  registered ID/EX contents
- stall_cnt  out  32  cycles in which id_stall was 1

## Operation
- Source match for stage S (EX, MEM, WB): use=1, rs≠0, S writes (ex_valid&ex_rd_we / mem_rd_we / wb_we), and S.rd==rs.
- The operand for each source uses the first match in priority order:
  - EX, non-load: ex_result
  - MEM: mem_data
  - WB: wb_data
  - otherwise: rf_rdN
- rs=0 always yields 0.
- Load-use hazard: id_valid, and an EX match on either used source where ex_is_load=1.
- id_stall = (load-use hazard | ex_hold) & ~flush.
- ID/EX register update on each posedge, first true case wins:
  1. rst=0: ex_valid=0, all ex_* fields=0, stall_cnt=0.
  2. flush=1: load a bubble (ex_valid=0, ex_rd_we=0, other fields don't-care, cleared to 0). The branch in EX is complete, so flush wins over ex_hold.
  3. ex_hold=1: hold all ex_* fields unchanged.
  4. Load-use hazard: load a bubble.
  5. Otherwise: load the ID instruction with forwarded operands; ex_valid=id_valid.
  - ex_rd_we and ex_is_load are loaded gated by id_valid.
- stall_cnt increments by 1, wrapping at 2^32, on every non-reset cycle with id_stall=1.
- An invalid ID instruction (id_valid=0) never causes a stall.

## Timing
- Issue latency: 1 cycle from ID to ex_* outputs.
- rf_a1/rf_a2 and id_stall are combinational from ID inputs, registered ID/EX state, and MEM/WB inputs; no combinational path from id_stall back into ex_result is permitted.
- Load-use costs exactly 1 bubble. On the next cycle the load is in MEM and mem_data forwards.
- Back-to-back dependent ALU ops incur 0 bubbles.
- The RF writes on negedge, so WB data is also visible through rf_rdN. The WB bypass is still required and must agree.
- ex_hold asserted N cycles: ex_* frozen N cycles, id_stall=1 N cycles, stall_cnt += N.
- Reset mid-operation: the next posedge with rst=0 clears everything; in-flight instructions are lost.

## Test plan
- Reset: hold rst=0 with active inputs for 2 cycles → ex_valid=0, ex_op1=ex_op2=0, stall_cnt=0, id_stall follows only the hazard terms.
- Forwarding priority: rs1=5, with EX writing r5 (non-load, ex_result=0x11), MEM r5 (0x22), WB r5 (0x33) → ex_op1=0x11. Remove EX → 0x22. Remove MEM → 0x33. Remove WB → rf_rd1.
- x0: rs1=0, all stages writing r0 with 0xFFFFFFFF → ex_op1=0, no stall.
- Load-use: EX load to r7, ID uses rs2=7 → id_stall=1 for 1 cycle, bubble (ex_valid=0), stall_cnt=1. The next cycle issues with ex_op2=mem_data. Same case with id_use2=0 → no stall.
- Hold: ex_hold=1 for 3 cycles → ex_* unchanged, id_stall=1 each cycle, stall_cnt=3.
- Flush during hold and during load-use → next ex_valid=0, id_stall=0 that cycle, and stall_cnt does not increment.
